// File: rtl/rrp_otf_converter_pkg.sv
// rrp_otf_converter_pkg: radix/width defaults, derived widths and legal-digit range for the redundant-radix datapath
package rrp_otf_converter_pkg;
   localparam int RADIX_DEF = 8;
   localparam int WIDTH_DEF = 5;
   function automatic int k_of(input int radix);
      return $clog2(radix);
   endfunction
   function automatic int d_of(input int radix);
      return $clog2(radix) + 1;
   endfunction
   function automatic int rw_of(input int radix, input int width);
      return $clog2(radix) * width + 1;
   endfunction
   function automatic int dig_max(input int radix);
      return radix - 1;
   endfunction
   function automatic int dig_min(input int radix);
      return 1 - radix;
   endfunction
endpackage

// File: rtl/rrp_otf_step.sv
// rrp_otf_step: combinational single-digit on-the-fly Q/QM update with illegal-digit flag
module rrp_otf_step
   import rrp_otf_converter_pkg::*;
#(
   parameter int RADIX = RADIX_DEF,
   parameter int WIDTH = WIDTH_DEF,
   localparam int K = k_of(RADIX),
   localparam int D = d_of(RADIX),
   localparam int RW = rw_of(RADIX, WIDTH)
) (
   input  logic [RW-1:0] q,
   input  logic [RW-1:0] qm,
   input  logic [D-1:0]  digit,
   output logic [RW-1:0] q_next,
   output logic [RW-1:0] qm_next,
   output logic          illegal
);
   localparam int DMIN = dig_min(RADIX);
   localparam int DMAX = dig_max(RADIX);
   logic neg, pos;
   logic [K-1:0] lo;
   assign neg = digit[D-1];
   assign pos = !neg && |digit[K-1:0];
   assign lo = digit[K-1:0];
   // RADIX+d and RADIX-1+d reduce mod RADIX to the digit's low bits and those bits minus one
   assign q_next = {neg ? qm[RW-K-1:0] : q[RW-K-1:0], lo};
   assign qm_next = {pos ? q[RW-K-1:0] : qm[RW-K-1:0], lo - K'(1)};
   assign illegal = (int'($signed(digit)) < DMIN) || (int'($signed(digit)) > DMAX);
endmodule

// File: rtl/rrp_otf_converter.sv
// rrp_otf_converter: MSD-first signed-digit stream to two's-complement word converter with a single result buffer
module rrp_otf_converter
   import rrp_otf_converter_pkg::*;
#(
   parameter int RADIX = RADIX_DEF,
   parameter int WIDTH = WIDTH_DEF,
   localparam int K = k_of(RADIX),
   localparam int D = d_of(RADIX),
   localparam int RW = rw_of(RADIX, WIDTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [D-1:0]  in_digit,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [RW-1:0] out_value,
   output logic          out_err,
   output logic          out_valid,
   input  logic          out_ready
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   logic [CW-1:0] cnt;
   logic [RW-1:0] q, qm, q_next, qm_next;
   logic err, illegal, accept, last;
   rrp_otf_step #(.RADIX(RADIX), .WIDTH(WIDTH)) u_step (
      .q(q),
      .qm(qm),
      .digit(in_digit),
      .q_next(q_next),
      .qm_next(qm_next),
      .illegal(illegal)
   );
   assign in_ready = !out_valid || out_ready;
   assign accept = in_valid && in_ready;
   assign last = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         q <= '0;
         qm <= '1;
         err <= 1'b0;
         out_valid <= 1'b0;
         out_value <= '0;
         out_err <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= last ? '0 : cnt + CW'(1);
            q <= last ? '0 : q_next;
            qm <= last ? '1 : qm_next;
            err <= last ? 1'b0 : err | illegal;
         end
         // a final digit landing on an output handshake reloads the buffer with no bubble
         if (accept && last) begin
            out_value <= q_next;
            out_err <= err | illegal;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rrp_otf_converter.sv
// tb_rrp_otf_converter: directed and randomized-handshake checks of the on-the-fly converter
module tb_rrp_otf_converter;
   logic clock = 1'b0;
   logic reset;
   logic [3:0] in_digit;
   logic in_valid;
   logic in_ready;
   logic [15:0] out_value;
   logic out_err;
   logic out_valid;
   logic out_ready;
   int checks = 0;
   int errors = 0;

   rrp_otf_converter dut (
      .clock(clock),
      .reset(reset),
      .in_digit(in_digit),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_value(out_value),
      .out_err(out_err),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // digits packed MSD first, one nibble each; out_ready must be high
   task automatic send(input logic [19:0] w);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_digit = w[19-4*i -: 4];
         @(negedge clock);
         if (i < 4) chk("busy_no_valid", out_valid, 0);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int acc, n, got, sent, cyc, dd;
      logic [15:0] expq[$];
      reset = 1'b1;
      in_valid = 1'b0;
      in_digit = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_value", out_value, 0);
      chk("rst_err", out_err, 0);

      send(20'h1F000);
      chk("w1_valid", out_valid, 1);
      chk("w1_value", out_value, 16'h0E00);
      chk("w1_err", out_err, 0);
      @(negedge clock);
      chk("w1_drain", out_valid, 0);

      send(20'h77777);
      chk("max_value", out_value, 16'h7FFF);
      send(20'h99999);
      chk("min_value", out_value, 16'h8001);
      send(20'h0000F);
      chk("m1_value", out_value, 16'hFFFF);

      send(20'h00800);
      chk("bad_err", out_err, 1);
      chk("bad_value", out_value, 16'hFE00);
      send(20'h00001);
      chk("clean_err", out_err, 0);
      chk("clean_value", out_value, 16'h0001);

      send(20'h11111);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_digit = 4'h2;
      repeat (3) @(negedge clock);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_value, 16'h1249);
      chk("bp_ready", in_ready, 0);
      out_ready = 1'b1;
      send(20'h22222);
      chk("bp_w2", out_value, 16'h2492);

      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_digit = 4'h5;
         @(negedge clock);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      send(20'h00003);
      chk("after_rst_value", out_value, 16'h0003);
      chk("after_rst_err", out_err, 0);
      @(negedge clock);

      acc = 0; n = 0; got = 0; sent = 0; cyc = 0;
      while (got < 300 && cyc < 20000) begin
         dd = int'($urandom_range(14)) - 7;
         in_valid = (sent < 300) && ($urandom_range(3) != 0);
         in_digit = 4'(dd);
         out_ready = $urandom_range(3) != 0;
         #1;
         if (in_valid && in_ready) begin
            acc = acc * 8 + dd;
            n++;
            if (n == 5) begin
               expq.push_back(16'(acc));
               acc = 0;
               n = 0;
               sent++;
            end
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("rand_spurious", 1, 0);
            else begin
               chk("rand_value", out_value, expq.pop_front());
               chk("rand_err", out_err, 0);
            end
            got++;
         end
         @(negedge clock);
         cyc++;
      end
      chk("rand_words", got, 300);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
